// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage: FSM state and the buffered fetch entry.
package fetch_pkg;

    localparam int unsigned ADDR_WIDTH = 64;
    localparam int unsigned DATA_WIDTH = 32;

    typedef enum logic {
        RUN,
        HALT
    } fetch_state_e;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] inst;
        logic                  fault;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries with flush; pointers wrap naturally (power-of-two depth).
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  fetch_entry_t             entry_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output fetch_entry_t             head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    fetch_entry_t    mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q,  count_d;
    logic            do_pop;

    assign do_pop = pop_i && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({push_i, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the head is only observed when the count is non-zero.
    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) begin
            mem_q[wr_ptr_q] <= entry_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch: PC generation, combinational ROM addressing, fetch buffering and
// redirect/fault handling in front of the decoder.
module ifu_fetch
    import fetch_pkg::*;
#(
    parameter int unsigned          ADDR_WIDTH = 64,
    parameter int unsigned          DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC  = '0,
    parameter int unsigned          FIFO_DEPTH = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    output logic [ADDR_WIDTH-1:0] rom_addr_o,
    input  logic [DATA_WIDTH-1:0] rom_data_i,
    input  logic                  rom_illegal_i,
    input  logic                  redirect_valid_i,
    input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
    output logic                  inst_valid_o,
    input  logic                  inst_ready_i,
    output logic [DATA_WIDTH-1:0] inst_o,
    output logic [ADDR_WIDTH-1:0] pc_o,
    output logic                  fault_o
);

    localparam int unsigned EAW = fetch_pkg::ADDR_WIDTH;
    localparam int unsigned EDW = fetch_pkg::DATA_WIDTH;
    localparam int unsigned CW  = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  push, pop;
    logic                  fifo_full, fifo_empty;
    logic [CW-1:0]         fifo_count;
    fetch_entry_t          wr_entry, head;

    assign pop = inst_valid_o && inst_ready_i;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        push     = 1'b0;
        wr_entry = '0;
        if (redirect_valid_i) begin
            pc_d    = redirect_pc_i;
            state_d = RUN;
        end else if (state_q == RUN && (!fifo_full || pop)) begin
            push        = 1'b1;
            wr_entry.pc = EAW'(pc_q);
            if (rom_illegal_i) begin
                wr_entry.fault = 1'b1;
                state_d        = HALT;
            end else begin
                wr_entry.inst = EDW'(rom_data_i);
                pc_d          = pc_q + ADDR_WIDTH'(4);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .entry_i (wr_entry),
        .pop_i   (pop),
        .flush_i (redirect_valid_i),
        .head_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assert property (@(posedge clk_i) disable iff (!rst_ni) fifo_count <= CW'(FIFO_DEPTH));

    assign rom_addr_o   = pc_q;
    assign inst_valid_o = !fifo_empty;
    assign inst_o       = inst_valid_o ? head.inst[DATA_WIDTH-1:0] : '0;
    assign pc_o         = inst_valid_o ? head.pc[ADDR_WIDTH-1:0]   : '0;
    assign fault_o      = inst_valid_o ? head.fault                : 1'b0;

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: directed scenarios plus randomized traffic against a queue model.
module tb_ifu_fetch;

    localparam int unsigned DEPTH = 2;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
        bit          fault;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] rom_addr, rom_addr_w;
    logic [31:0] rom_data, rom_data_w;
    logic        rom_ill, rom_ill_w;
    logic        redir_v = 1'b0;
    logic [63:0] redir_pc = '0;
    logic        ready = 1'b0;
    logic        valid, valid_w;
    logic [31:0] inst, inst_w;
    logic [63:0] pc, pc_w;
    logic        fault, fault_w;

    int unsigned total = 0;
    int unsigned bad = 0;

    exp_t        mq[$];
    logic [63:0] m_pc;
    bit          m_halt;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [63:0] a);
        if (a == 64'h0)      return 32'h0000_0013;
        else if (a == 64'h4) return 32'h0010_0093;
        else if (a == 64'h8) return 32'h0020_0113;
        else                 return (a[31:0] * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    assign rom_data   = rom_word(rom_addr);
    assign rom_ill    = (rom_addr[1:0] != 2'b00);
    assign rom_data_w = rom_word(rom_addr_w);
    assign rom_ill_w  = (rom_addr_w[1:0] != 2'b00);

    ifu_fetch #(
        .ADDR_WIDTH (64),
        .DATA_WIDTH (32),
        .RESET_PC   (64'h0),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .rom_addr_o       (rom_addr),
        .rom_data_i       (rom_data),
        .rom_illegal_i    (rom_ill),
        .redirect_valid_i (redir_v),
        .redirect_pc_i    (redir_pc),
        .inst_valid_o     (valid),
        .inst_ready_i     (ready),
        .inst_o           (inst),
        .pc_o             (pc),
        .fault_o          (fault)
    );

    ifu_fetch #(
        .ADDR_WIDTH (64),
        .DATA_WIDTH (32),
        .RESET_PC   (64'hFFFF_FFFF_FFFF_FFFC),
        .FIFO_DEPTH (DEPTH)
    ) dut_wrap (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .rom_addr_o       (rom_addr_w),
        .rom_data_i       (rom_data_w),
        .rom_illegal_i    (rom_ill_w),
        .redirect_valid_i (1'b0),
        .redirect_pc_i    (64'h0),
        .inst_valid_o     (valid_w),
        .inst_ready_i     (1'b1),
        .inst_o           (inst_w),
        .pc_o             (pc_w),
        .fault_o          (fault_w)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pc   = 64'h0;
        m_halt = 1'b0;
    endtask

    // One clock of the fetch rules: redirect flushes; otherwise pop then refill if there is room.
    task automatic model_step(input bit rdy, input bit rv, input logic [63:0] rpc);
        exp_t e;
        bit   pop;
        pop = (mq.size() > 0) && rdy;
        if (rv) begin
            mq.delete();
            m_pc   = rpc;
            m_halt = 1'b0;
        end else begin
            if (pop) void'(mq.pop_front());
            if (!m_halt && mq.size() < DEPTH) begin
                e.pc = m_pc;
                if (m_pc[1:0] != 2'b00) begin
                    e.inst  = 32'h0;
                    e.fault = 1'b1;
                    m_halt  = 1'b1;
                end else begin
                    e.inst  = rom_word(m_pc);
                    e.fault = 1'b0;
                    m_pc    = m_pc + 64'd4;
                end
                mq.push_back(e);
            end
        end
    endtask

    task automatic check_outputs();
        check("rom_addr", rom_addr, m_pc);
        check("valid", {63'b0, valid}, {63'b0, mq.size() > 0});
        if (mq.size() > 0) begin
            check("pc", pc, mq[0].pc);
            check("inst", {32'b0, inst}, {32'b0, mq[0].inst});
            check("fault", {63'b0, fault}, {63'b0, mq[0].fault});
        end else begin
            check("pc_empty", pc, 64'h0);
            check("inst_empty", {32'b0, inst}, 64'h0);
            check("fault_empty", {63'b0, fault}, 64'h0);
        end
    endtask

    task automatic step();
        model_step(ready, redir_v, redir_pc);
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic pulse_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_valid", {63'b0, valid}, 64'h0);
        check("rst_pc", pc, 64'h0);
        check("rst_addr", rom_addr, 64'h0);
        #4;
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        #12;
        check("reset_valid", {63'b0, valid}, 64'h0);
        check("reset_addr", rom_addr, 64'h0);
        check("reset_addr_wrap", rom_addr_w, 64'hFFFF_FFFF_FFFF_FFFC);
        rst_n = 1'b1;

        // Streaming from reset, plus the wrap-around instance.
        ready = 1'b1;
        step();
        check("first_pc", pc, 64'h0);
        check("wrap_first_pc", pc_w, 64'hFFFF_FFFF_FFFF_FFFC);
        step();
        check("second_pc", pc, 64'h4);
        check("wrap_second_pc", pc_w, 64'h0);
        check("wrap_no_fault", {63'b0, fault_w}, 64'h0);
        step();
        check("third_pc", pc, 64'h8);

        // Backpressure from a fresh reset: buffer fills with 0x0/0x4, PC parks at 0x8.
        ready = 1'b0;
        pulse_reset();
        repeat (5) step();
        check("bp_addr_stuck", rom_addr, 64'h8);
        check("bp_head", pc, 64'h0);

        // Redirect with a pop in the same cycle.
        ready    = 1'b1;
        redir_v  = 1'b1;
        redir_pc = 64'h100;
        step();
        redir_v = 1'b0;
        check("redir_gap", {63'b0, valid}, 64'h0);
        step();
        check("redir_target", pc, 64'h100);

        // Misaligned redirect faults and halts until the next redirect.
        redir_v  = 1'b1;
        redir_pc = 64'h102;
        step();
        redir_v = 1'b0;
        ready   = 1'b0;
        step();
        check("fault_flag", {63'b0, fault}, 64'h1);
        check("fault_inst", {32'b0, inst}, 64'h0);
        ready = 1'b1;
        repeat (10) step();
        check("halt_idle", {63'b0, valid}, 64'h0);
        redir_v  = 1'b1;
        redir_pc = 64'h200;
        step();
        redir_v = 1'b0;
        step();
        check("resume_pc", pc, 64'h200);

        // Async reset while full.
        ready = 1'b0;
        repeat (3) step();
        pulse_reset();
        ready = 1'b1;
        step();
        check("restart_pc", pc, 64'h0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            ready   = ($urandom_range(0, 3) != 0);
            redir_v = ($urandom_range(0, 9) == 0);
            redir_pc = {52'h0, 10'($urandom_range(0, 1023)), 2'b00};
            if ($urandom_range(0, 4) == 0) redir_pc[1:0] = 2'($urandom_range(1, 3));
            step();
        end
        redir_v = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ifu_fetch.md
# ifu_fetch

Instruction fetch stage that generates the program counter, drives the combinational instruction ROM address, and buffers fetched words in a small FIFO. It presents them to decode over a valid/ready handshake. The block sits between the code ROM (upstream) and the decoder (downstream). It handles branch/jump redirects with a full flush and stops fetching after an unaligned-access fault until redirected.

## Interface
Parameters:
- ADDR_WIDTH, 64, PC / ROM address width
- DATA_WIDTH, 32, instruction width
- RESET_PC, 64'h0, PC loaded at reset
- FIFO_DEPTH, 2, buffered entries (power of two, ≥2)

Ports (one clock; reset is asynchronous and active-low):
- clk_i  in  1  clock
- rst_ni  in  1  async active-low reset
- rom_addr_o  out  ADDR_WIDTH  ROM address, always equal to pc_q
- rom_data_i  in  DATA_WIDTH  ROM word, combinational from rom_addr_o
- rom_illegal_i  in  1  ROM unaligned-access flag, combinational
- redirect_valid_i  in  1  flush request and new PC from execute
- redirect_pc_i  in  ADDR_WIDTH  redirect target
- inst_valid_o  out  1  FIFO head valid
- inst_ready_i  in  1  decode accepts head
- inst_o  out  DATA_WIDTH  head instruction
- pc_o  out  ADDR_WIDTH  head PC
- fault_o  out  1  head entry is an access fault

## Operation
- State machine fetch_state_e has two states: RUN and HALT.
- Reset: pc_q=RESET_PC, FIFO empty, state RUN. Outputs: inst_valid_o=0, inst_o=0, pc_o=0, fault_o=0, rom_addr_o=RESET_PC.
- pop = inst_valid_o && inst_ready_i.
- push = (state==RUN) && !redirect_valid_i && (count<FIFO_DEPTH || pop).
- On push:
  - Write entry {pc_q, rom_data_i, rom_illegal_i}.
  - If rom_illegal_i=0: pc_q += 4, modulo 2^ADDR_WIDTH (wrap, no flag).
  - If rom_illegal_i=1: pc_q holds and state moves to HALT. The entry's inst field is 0 and fault=1.
- HALT: no push and pc_q holds. The FIFO keeps draining normally. The only exit is a redirect.
- Redirect (highest priority):
  - Next cycle: FIFO count=0, pc_q=redirect_pc_i, state RUN.
  - No push in the redirect cycle.
  - A pop in the same cycle still counts as a completed transfer.
- Redirect targets are not checked. A misaligned target produces a fault entry through the ROM flag.
- Count arithmetic: count is $clog2(FIFO_DEPTH)+1 bits. Read/write pointers wrap modulo FIFO_DEPTH.
- Empty FIFO: inst_valid_o=0 and inst_o/pc_o/fault_o are forced to 0.

## Timing
- ROM access is zero-latency. The fetch-to-valid latency is 1 cycle because the FIFO is registered.
- First cycle after rst_ni rises: push at RESET_PC. inst_valid_o=1 on the next cycle.
- Redirect asserted in cycle N:
  - Cycle N+1: inst_valid_o=0 and rom_addr_o=redirect_pc_i.
  - Cycle N+2: inst_valid_o=1 with pc_o=redirect_pc_i.
- Sustained throughput with inst_ready_i held high is 1 instruction/cycle.
- Full FIFO with pop in the same cycle: push proceeds and count is unchanged.
- Full FIFO without pop: pc_q holds and rom_addr_o is stable.
- Once inst_valid_o is asserted, the head must not change until it is popped or a redirect occurs.
- Reset asserted mid-operation: all state clears immediately (async). Outputs take reset values without waiting for a clock edge.

## Structure
- fetch_pkg contains:
  - fetch_state_e {RUN, HALT}
  - fetch_entry_t struct {pc, inst, fault}, sized by package parameters ADDR_WIDTH/DATA_WIDTH defaulting to 64/32
- One sub-module, fetch_fifo: parameterised synchronous FIFO of fetch_entry_t with push/pop/flush and full/empty/count outputs. It uses the same clk_i/rst_ni.
- The top level holds pc_q, the state register, and push/redirect logic.

## Test plan
- Reset release, ROM words 0x00000013, 0x00100093, 0x00200113 at 0x0/0x4/0x8, ready=1 → entries with pc_o 0x0, 0x4, 0x8 on consecutive cycles starting 1 cycle after reset release; fault_o=0.
- Backpressure with ready=0 for 5 cycles → count saturates at 2 and rom_addr_o is stuck at 0x8. When ready=1, the order is 0x0, 0x4, 0x8 with no loss or duplication.
- Redirect to 0x100 while the FIFO holds 2 entries, with ready=1 in the same cycle → the 0x0 head counts as transferred. The next valid entry has pc_o=0x100 two cycles after the redirect, and the stale 0x4 entry never appears.
- Redirect to 0x102 → an entry with pc_o=0x102, fault_o=1, inst_o=0. The state enters HALT with no further pushes over 10 cycles. A redirect to 0x200 resumes fetching at 0x200.
- rst_ni pulsed low for half a cycle while the FIFO is full → inst_valid_o=0 immediately. After release, fetching restarts at RESET_PC.
- RESET_PC=64'hFFFF_FFFF_FFFF_FFFC → the second entry has pc_o=0x0 (wrap), and no fault is raised.
